// File: rtl/axis_spi_master_cfg.sv
// AXI-Stream SPI master with per-frame CPOL/CPHA, bit order and SCLK divider.
// TX words from s_axis become SPI words; each received word goes out on m_axis.
module axis_spi_master_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int SLAVE_NUM  = 2,
  parameter int DIV_WIDTH  = 8,
  parameter int GAP_CYCLES = 16,
  parameter int SEL_W      = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cfg_cpol_i,
  input  logic                  cfg_cpha_i,
  input  logic                  cfg_lsb_first_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [SEL_W-1:0]      s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  spi_clk_o,
  output logic [SLAVE_NUM-1:0]  spi_cs_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i,
  output logic                  busy_o
);

  localparam int EDGES = 2 * DATA_WIDTH;
  localparam int ECW   = $clog2(EDGES + 1);
  localparam int GCW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StNext, StHold, StGap} state_e;

  state_e                state_q, state_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, hp_q, hp_d;
  logic [ECW-1:0]        edge_q, edge_d;
  logic [GCW-1:0]        gap_q, gap_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, md_q, md_d;
  logic                  last_q, last_d, ml_q, ml_d, mv_q, mv_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d;
  logic [SLAVE_NUM-1:0]  cs_q, cs_d;

  logic hp_zero, s_hs, leading, ld_cpha, ld_lsb;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] d,
                                                     input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  // Accept a word only when the RX slot is empty or being drained this cycle.
  assign s_axis_tready = ~arst_i & ((state_q == StIdle) || (state_q == StNext)) &
                         (~mv_q | m_axis_tready);
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign hp_zero       = (hp_q == '0);
  // Config used for the word being loaded: fresh in IDLE, latched in NEXT.
  assign ld_cpha       = (state_q == StIdle) ? cfg_cpha_i : cpha_q;
  assign ld_lsb        = (state_q == StIdle) ? cfg_lsb_first_i : lsb_q;

  assign m_axis_tvalid = mv_q;
  assign m_axis_tdata  = md_q;
  assign m_axis_tlast  = ml_q;
  assign spi_clk_o     = sclk_q;
  assign spi_cs_o      = cs_q;
  assign spi_mosi_o    = mosi_q;
  assign busy_o        = (state_q != StIdle);

  // Next-state logic for the frame sequencer and SPI shift datapath.
  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    div_d   = div_q;
    hp_d    = hp_q;
    edge_d  = edge_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    last_d  = last_q;
    md_d    = md_q;
    ml_d    = ml_q;
    mv_d    = mv_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    leading = 1'b0;

    if (mv_q && m_axis_tready) mv_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        sclk_d = cfg_cpol_i;
        if (s_hs) begin
          cpol_d  = cfg_cpol_i;
          cpha_d  = cfg_cpha_i;
          lsb_d   = cfg_lsb_first_i;
          div_d   = cfg_div_i;
          // Out-of-range slave index selects nothing; the transfer still runs.
          for (int i = 0; i < SLAVE_NUM; i++) cs_d[i] = (s_axis_tuser != SEL_W'(i));
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (hp_zero) begin
          hp_d    = div_q;
          edge_d  = ECW'(EDGES);
          state_d = StXfer;
        end else begin
          hp_d = hp_q - DIV_WIDTH'(1);
        end
      end
      StXfer: begin
        if (edge_q == '0) begin
          // Completion cycle; the HOLD half-period keeps counting from the last edge.
          if (!hp_zero) hp_d = hp_q - DIV_WIDTH'(1);
          mv_d    = 1'b1;
          md_d    = rx_q;
          ml_d    = last_q;
          state_d = last_q ? StHold : StNext;
        end else if (hp_zero) begin
          hp_d    = div_q;
          edge_d  = edge_q - ECW'(1);
          sclk_d  = ~sclk_q;
          leading = ~edge_q[0];
          if (leading ^ cpha_q) begin
            rx_d = lsb_q ? {spi_miso_i, rx_q[DATA_WIDTH-1:1]}
                         : {rx_q[DATA_WIDTH-2:0], spi_miso_i};
          end
          if (cpha_q ? leading : (!leading && edge_q != ECW'(1))) begin
            mosi_d = first_bit(tx_q, lsb_q);
            tx_d   = shift_tx(tx_q, lsb_q);
          end
        end else begin
          hp_d = hp_q - DIV_WIDTH'(1);
        end
      end
      StNext: begin
        sclk_d = cpol_q;
        if (s_hs) begin
          edge_d  = ECW'(EDGES);
          state_d = StXfer;
        end
      end
      StHold: begin
        sclk_d = cpol_q;
        if (hp_zero) begin
          cs_d    = '1;
          gap_d   = GCW'(GAP_CYCLES - 1);
          state_d = StGap;
        end else begin
          hp_d = hp_q - DIV_WIDTH'(1);
        end
      end
      StGap: begin
        sclk_d = cpol_q;
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GCW'(1);
      end
      default: state_d = StIdle;
    endcase

    // Common word load on any TX handshake; CPHA=0 puts the first bit out now.
    if (s_hs) begin
      last_d = s_axis_tlast;
      hp_d   = (state_q == StIdle) ? cfg_div_i : div_q;
      if (ld_cpha) begin
        tx_d = s_axis_tdata;
      end else begin
        mosi_d = first_bit(s_axis_tdata, ld_lsb);
        tx_d   = shift_tx(s_axis_tdata, ld_lsb);
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= StIdle;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      div_q   <= '0;
      hp_q    <= '0;
      edge_q  <= '0;
      gap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      last_q  <= 1'b0;
      md_q    <= '0;
      ml_q    <= 1'b0;
      mv_q    <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= '1;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      edge_q  <= edge_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      last_q  <= last_d;
      md_q    <= md_d;
      ml_q    <= ml_d;
      mv_q    <= mv_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
    end
  end

endmodule

// File: tb/tb_axis_spi_master_cfg.sv
// Directed bench for axis_spi_master_cfg: vector table plus corner-case sequences.
module tb_axis_spi_master_cfg;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic       cfg_cpol_i, cfg_cpha_i, cfg_lsb_first_i;
  logic [7:0] cfg_div_i;
  logic       s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0] s_axis_tdata;
  logic [1:0] s_axis_tuser;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       spi_clk_o, spi_mosi_o, spi_miso_i, busy_o;
  logic [1:0] spi_cs_o;

  axis_spi_master_cfg #(
    .DATA_WIDTH(8), .SLAVE_NUM(2), .DIV_WIDTH(8), .GAP_CYCLES(4), .SEL_W(2)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i),
    .cfg_lsb_first_i(cfg_lsb_first_i), .cfg_div_i(cfg_div_i),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .spi_clk_o(spi_clk_o), .spi_cs_o(spi_cs_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic cpol; logic cpha; logic lsb; logic [7:0] div; logic [1:0] user;
    logic [7:0] tx; logic [7:0] sl_word; logic lpbk;
    logic [7:0] exp_rx; logic [7:0] exp_cap; int exp_cs0; int exp_cs1;
  } vec_t;

  typedef struct packed {logic last; logic [7:0] data;} beat_t;

  vec_t  vecs[6];
  beat_t rxq[$];
  int    n_checks = 0, n_fail = 0;
  int    cs0_low = 0, cs1_low = 0, cs1_rises = 0, rises = 0, sclk_edges = 0, cap_n = 0;
  logic [7:0] cap = '0, sl_word = '0;
  logic  cur_cpol = 1'b0, cur_cpha = 1'b0, lpbk = 1'b1, sl_bit = 1'b0;
  int    sl_idx = 0;
  logic  cs_any;

  assign cs_any     = ~&spi_cs_o;
  assign spi_miso_i = lpbk ? spi_mosi_o : sl_bit;

  // Slave model (MSB first) and bus observer: capture MOSI at the mode's sample edge.
  always @(posedge cs_any) begin
    if (cur_cpha) sl_idx = 0;
    else begin sl_bit = sl_word[7]; sl_idx = 1; end
  end

  always @(spi_clk_o) begin
    sclk_edges++;
    if (spi_clk_o) rises++;
    if ((spi_clk_o != cur_cpol) ^ cur_cpha) begin cap = {cap[6:0], spi_mosi_o}; cap_n++; end
    if (cs_any && ((spi_clk_o != cur_cpol) == cur_cpha)) begin
      if (sl_idx < 8) sl_bit = sl_word[7 - sl_idx];
      sl_idx++;
    end
  end

  always @(posedge spi_cs_o[1]) cs1_rises++;

  always @(negedge clk_i) begin
    if (!spi_cs_o[0]) cs0_low++;
    if (!spi_cs_o[1]) cs1_low++;
    #2;
    if (m_axis_tvalid && m_axis_tready) rxq.push_back({m_axis_tlast, m_axis_tdata});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [7:0] d, input logic last);
    beat_t b;
    if (rxq.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no RX word, required 0x%0h", name, d);
    end else begin
      b = rxq.pop_front();
      check({name, "_data"}, {24'd0, b.data}, {24'd0, d});
      check({name, "_last"}, {31'd0, b.last}, {31'd0, last});
    end
  endtask

  task automatic setup_cfg(input logic cpol, input logic cpha, input logic lsb,
                           input logic [7:0] div, input logic lb, input logic [7:0] sw);
    @(negedge clk_i);
    cfg_cpol_i = cpol; cfg_cpha_i = cpha; cfg_lsb_first_i = lsb; cfg_div_i = div;
    cur_cpol = cpol; cur_cpha = cpha; lpbk = lb; sl_word = sw;
    repeat (2) @(negedge clk_i);
    cs0_low = 0; cs1_low = 0; cs1_rises = 0; rises = 0; sclk_edges = 0; cap = '0; cap_n = 0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic last, input logic [1:0] user);
    int n;
    @(negedge clk_i);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last; s_axis_tuser = user;
    #1;
    n = 0;
    while (!s_axis_tready && n < 2000) begin @(negedge clk_i); #1; n++; end
    if (!s_axis_tready) begin
      n_checks++; n_fail++;
      $display("FAIL tx_handshake: tready 0 after %0d cycles, required 1", n);
    end
    @(posedge clk_i); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < 3000) begin @(negedge clk_i); n++; end
    if (busy_o) begin
      n_checks++; n_fail++;
      $display("FAIL %s: busy_o 1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    setup_cfg(v.cpol, v.cpha, v.lsb, v.div, v.lpbk, v.sl_word);
    check({tag, "_idle_pol"}, {31'd0, spi_clk_o}, {31'd0, v.cpol});
    send_word(v.tx, 1'b1, v.user);
    wait_idle({tag, "_idle"});
    pop_check({tag, "_rx"}, v.exp_rx, 1'b1);
    check({tag, "_mosi"}, {24'd0, cap}, {24'd0, v.exp_cap});
    check({tag, "_rises"}, rises, 8);
    check({tag, "_cs0_low"}, cs0_low, v.exp_cs0);
    check({tag, "_cs1_low"}, cs1_low, v.exp_cs1);
    check({tag, "_end_pol"}, {31'd0, spi_clk_o}, {31'd0, v.cpol});
    check({tag, "_cs_idle"}, {30'd0, spi_cs_o}, 32'd3);
  endtask

  initial begin
    int   n;
    logic bad;
    arst_i = 1'b1;
    cfg_cpol_i = 1'b0; cfg_cpha_i = 1'b0; cfg_lsb_first_i = 1'b0; cfg_div_i = 8'd1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    m_axis_tready = 1'b1;

    //           cpol  cpha  lsb   div    user  tx      slave   lpbk  rx      mosi   cs0 cs1
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5, 36, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'd1, 2'd0, 8'hF0, 8'h3C, 1'b0, 8'h3C, 8'hF0, 36, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 8'hF0, 8'h3C, 1'b0, 8'h3C, 8'hF0, 19, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'd2, 2'd0, 8'hF0, 8'h3C, 1'b0, 8'h3C, 8'hF0, 54, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd1, 2'd3, 8'h5A, 8'h00, 1'b1, 8'h5A, 8'h5A, 0, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 8'd1, 2'd1, 8'h0B, 8'h00, 1'b1, 8'h0B, 8'hD0, 0, 36};

    repeat (3) @(negedge clk_i);
    check("rst_cs", {30'd0, spi_cs_o}, 32'd3);
    check("rst_sclk", {31'd0, spi_clk_o}, 32'd0);
    check("rst_mosi", {31'd0, spi_mosi_o}, 32'd0);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    arst_i = 1'b0;
    @(negedge clk_i); #1;
    check("idle_s_tready", {31'd0, s_axis_tready}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Three-word LSB-first frame on slave 1: CS held across words, tlast only on word 3.
    setup_cfg(1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'h00);
    send_word(8'h01, 1'b0, 2'd1);
    send_word(8'h02, 1'b0, 2'd1);
    send_word(8'h03, 1'b1, 2'd1);
    wait_idle("multi_idle");
    pop_check("multi_w0", 8'h01, 1'b0);
    pop_check("multi_w1", 8'h02, 1'b0);
    pop_check("multi_w2", 8'h03, 1'b1);
    check("multi_cs1_rises", cs1_rises, 1);
    check("multi_cs0_low", cs0_low, 0);
    check("multi_bits", cap_n, 24);
    check("multi_mosi_lsb", {24'd0, cap}, 32'hC0);

    // RX backpressure: word 2 must wait until word 1 is drained.
    setup_cfg(1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00);
    m_axis_tready = 1'b0;
    send_word(8'h3A, 1'b0, 2'd0);
    @(negedge clk_i);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hC5; s_axis_tlast = 1'b1; s_axis_tuser = 2'd0;
    n = 0;
    while (!m_axis_tvalid && n < 500) begin @(negedge clk_i); n++; end
    check("bp_first_valid", {31'd0, m_axis_tvalid}, 32'd1);
    bad = 1'b0;
    repeat (40) begin @(negedge clk_i); #1; if (s_axis_tready) bad = 1'b1; end
    check("bp_tready_low", {31'd0, bad}, 32'd0);
    check("bp_sclk_stopped", rises, 8);
    check("bp_held_data", {24'd0, m_axis_tdata}, 32'h3A);
    check("bp_held_last", {31'd0, m_axis_tlast}, 32'd0);
    @(negedge clk_i);
    m_axis_tready = 1'b1;
    #1;
    check("bp_drain_accept", {31'd0, s_axis_tready}, 32'd1);
    @(posedge clk_i); #1;
    s_axis_tvalid = 1'b0;
    check("bp_drained", {31'd0, m_axis_tvalid}, 32'd0);
    check("bp_started", {31'd0, s_axis_tready}, 32'd0);
    wait_idle("bp_idle");
    pop_check("bp_w0", 8'h3A, 1'b0);
    pop_check("bp_w1", 8'hC5, 1'b1);

    // Asynchronous reset after five SCLK edges, then a clean frame.
    setup_cfg(1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00);
    send_word(8'h77, 1'b1, 2'd0);
    n = 0;
    while (sclk_edges < 5 && n < 200) begin @(posedge clk_i); #1; n++; end
    check("ar_edges", sclk_edges, 5);
    #2;
    arst_i = 1'b1;
    #1;
    check("ar_cs", {30'd0, spi_cs_o}, 32'd3);
    check("ar_sclk", {31'd0, spi_clk_o}, 32'd0);
    check("ar_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("ar_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("ar_busy", {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    check("ar_no_rx", rxq.size(), 0);
    run_vec(6, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
